// File: rtl/winner_policy_scan_pkg.sv
// winner_policy_scan_pkg: shared widths, FSM encoding, entry offsets and LFSR constants
package winner_policy_scan_pkg;
    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int OFS_ID = 0;
    localparam int OFS_Q = 1;
    localparam int OFS_HOP = 2;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    // taps 16,14,13,11 map to bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    typedef enum logic [4:0] {
        S_IDLE = 5'd0,
        S_RD_CNT = 5'd1,
        S_LD_CNT = 5'd2,
        S_RD_ID = 5'd3,
        S_LD_ID = 5'd4,
        S_RD_Q = 5'd5,
        S_LD_Q = 5'd6,
        S_RD_HOP = 5'd7,
        S_LD_HOP = 5'd8,
        S_CMP = 5'd9,
        S_WR_ID = 5'd10,
        S_WR_HOP = 5'd11,
        S_DONE = 5'd12
    } state_t;
endpackage

// File: rtl/winner_policy_scan_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, zero seed replaced by the default seed
module lfsr16
    import winner_policy_scan_pkg::*;
(
    input  logic        clock,
    input  logic        nrst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);
    // shift every enabled cycle, feedback enters at bit 0
    always_ff @(posedge clock) begin
        if (!nrst) state <= (seed == 16'h0) ? LFSR_DEFAULT_SEED : seed;
        else if (en) state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
endmodule

// File: rtl/winner_policy_scan.sv
// winner_policy_scan: scans a neighbour table in memory and writes back the best next hop
// Optional random tie-break on full ties enabled by defining WINNER_RNG_TIEBREAK_EN.
module winner_policy_scan
    import winner_policy_scan_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_NEIGHBORS = 16,
    parameter logic [ADDR_WIDTH-1:0] CNT_ADDR = 11'h010,
    parameter logic [ADDR_WIDTH-1:0] TABLE_BASE = 11'h020,
    parameter int ENTRY_STRIDE = 4,
    parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR = 11'h008,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  found,
    output logic [WORD_WIDTH-1:0] winner_id,
    output logic [WORD_WIDTH-1:0] winner_hops
);
    localparam int CW = $clog2(MAX_NEIGHBORS + 1);

    state_t state, next;
    logic [CW-1:0] index, count, count_clamped;
    logic [WORD_WIDTH-1:0] cur_id, cur_q, cur_hops, best_id, best_q, best_hops;
    logic [ADDR_WIDTH-1:0] row;
    logic last, better, tie, tie_take, take;

`ifdef WINNER_RNG_TIEBREAK_EN
    logic [15:0] lfsr;
    lfsr16 u_lfsr (.clock(clock), .nrst(nrst), .en(en), .seed(LFSR_SEED), .state(lfsr));
    assign tie_take = lfsr[0];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign tie_take = 1'b0;
`endif

    assign row = TABLE_BASE + ADDR_WIDTH'(32'(index) * 32'(ENTRY_STRIDE));
    assign last = index == count - CW'(1);
    assign count_clamped = (data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ? CW'(MAX_NEIGHBORS) : CW'(data_in);
    assign better = cur_q > best_q || (cur_q == best_q && cur_hops < best_hops);
    assign tie = cur_q == best_q && cur_hops == best_hops;
    assign take = index == '0 || better || (tie && tie_take);

    // next-state decode and combinational memory interface
    always_comb begin
        next = state;
        address = '0;
        wr_en = 1'b0;
        data_out = '0;
        done = 1'b0;
        case (state)
            S_IDLE: next = start ? S_RD_CNT : S_IDLE;
            S_RD_CNT: begin
                address = CNT_ADDR;
                next = S_LD_CNT;
            end
            S_LD_CNT: next = (data_in == '0) ? S_DONE : S_RD_ID;
            S_RD_ID: begin
                address = row + ADDR_WIDTH'(OFS_ID);
                next = S_LD_ID;
            end
            S_LD_ID: next = S_RD_Q;
            S_RD_Q: begin
                address = row + ADDR_WIDTH'(OFS_Q);
                next = S_LD_Q;
            end
            S_LD_Q: next = S_RD_HOP;
            S_RD_HOP: begin
                address = row + ADDR_WIDTH'(OFS_HOP);
                next = S_LD_HOP;
            end
            S_LD_HOP: next = S_CMP;
            S_CMP: next = last ? S_WR_ID : S_RD_ID;
            S_WR_ID: begin
                address = RESULT_ADDR;
                data_out = best_id;
                wr_en = en;
                next = S_WR_HOP;
            end
            S_WR_HOP: begin
                address = RESULT_ADDR + ADDR_WIDTH'(1);
                data_out = best_hops;
                wr_en = en;
                next = S_DONE;
            end
            S_DONE: begin
                done = en;
                next = S_IDLE;
            end
            default: next = S_IDLE;
        endcase
    end

    // state register and scan datapath; results publish on entry to DONE so found is valid with done
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state <= S_IDLE;
            index <= '0;
            count <= '0;
            cur_id <= '0;
            cur_q <= '0;
            cur_hops <= '0;
            best_id <= '0;
            best_q <= '0;
            best_hops <= '0;
            found <= 1'b0;
            winner_id <= '0;
            winner_hops <= '0;
        end else if (en) begin
            state <= next;
            case (state)
                S_IDLE: if (start) begin
                    index <= '0;
                    best_id <= '0;
                    best_q <= '0;
                    best_hops <= '0;
                    found <= 1'b0;
                    winner_id <= '0;
                    winner_hops <= '0;
                end
                S_LD_CNT: count <= count_clamped;
                S_LD_ID: cur_id <= data_in;
                S_LD_Q: cur_q <= data_in;
                S_LD_HOP: cur_hops <= data_in;
                S_CMP: begin
                    if (take) begin
                        best_id <= cur_id;
                        best_q <= cur_q;
                        best_hops <= cur_hops;
                    end
                    if (!last) index <= index + CW'(1);
                end
                S_WR_HOP: begin
                    found <= 1'b1;
                    winner_id <= best_id;
                    winner_hops <= best_hops;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_winner_policy_scan.sv
// tb_winner_policy_scan: directed self-checking bench with a behavioural word memory
module tb_winner_policy_scan;
    logic clock = 1'b0;
    logic nrst = 1'b0;
    logic en = 1'b1;
    logic start = 1'b0;
    logic [15:0] data_in;
    logic [10:0] address;
    logic wr_en;
    logic [15:0] data_out;
    logic done, found;
    logic [15:0] winner_id, winner_hops;

    logic [15:0] mem [0:2047];
    logic [15:0] rd = 16'h0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int checks = 0;
    int errors = 0;
`ifdef WINNER_RNG_TIEBREAK_EN
    logic [15:0] ref_lfsr = 16'hACE1;
    logic tie_bit = 1'b0;
`endif

    winner_policy_scan dut (
        .clock(clock), .nrst(nrst), .en(en), .start(start), .data_in(data_in),
        .address(address), .wr_en(wr_en), .data_out(data_out), .done(done),
        .found(found), .winner_id(winner_id), .winner_hops(winner_hops)
    );

    always #5 clock = ~clock;
    assign data_in = rd;

    always @(posedge clock) begin
        if (wr_en) begin
            mem[address] <= data_out;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        rd <= mem[address];
    end

`ifdef WINNER_RNG_TIEBREAK_EN
    always @(posedge clock) begin
        if (!nrst) ref_lfsr <= 16'hACE1;
        else if (en) ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
    end
`endif

    task automatic set_entry(input int i, input int id, input int q, input int h);
        mem[11'h020 + 4 * i] = 16'(id);
        mem[11'h020 + 4 * i + 1] = 16'(q);
        mem[11'h020 + 4 * i + 2] = 16'(h);
    endtask

    task automatic run_scan(input int pause_at, output int lat);
        @(negedge clock);
        wr_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 1000) begin
`ifdef WINNER_RNG_TIEBREAK_EN
            if (lat == 23) tie_bit = ref_lfsr[0];
`endif
            en = !(pause_at > 0 && lat >= pause_at && lat < pause_at + 5);
            @(negedge clock);
            lat++;
        end
        en = 1'b1;
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset_found got %b want 0", found); end
        checks++; if (winner_id !== 16'h0 || winner_hops !== 16'h0) begin errors++; $display("FAIL reset_winner got %h/%h want 0/0", winner_id, winner_hops); end
        checks++; if (wr_en !== 1'b0 || address !== 11'h0 || data_out !== 16'h0) begin errors++; $display("FAIL reset_bus got %b/%h/%h want 0/0/0", wr_en, address, data_out); end
        nrst = 1'b1;
    endtask

    task automatic test_count_zero;
        int lat;
        mem[11'h010] = 16'd0;
        run_scan(0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL zero_latency got %0d want 3", lat); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL zero_found got %b want 0", found); end
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL zero_writes got %0d want 0", wr_cnt); end
    endtask

    task automatic test_single;
        int lat;
        mem[11'h010] = 16'd1;
        set_entry(0, 7, 40, 3);
        run_scan(0, lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL single_latency got %0d want 12", lat); end
        checks++; if (found !== 1'b1 || winner_id !== 16'd7 || winner_hops !== 16'd3) begin errors++; $display("FAIL single_result got %b/%0d/%0d want 1/7/3", found, winner_id, winner_hops); end
        checks++; if (mem[11'h008] !== 16'd7 || mem[11'h009] !== 16'd3) begin errors++; $display("FAIL single_mem got %0d/%0d want 7/3", mem[11'h008], mem[11'h009]); end
        @(negedge clock);
        checks++; if (done !== 1'b0 || done_cnt !== 1 || wr_cnt !== 2) begin errors++; $display("FAIL single_pulse got done=%b cnt=%0d wr=%0d want 0/1/2", done, done_cnt, wr_cnt); end
        checks++; if (found !== 1'b1 || winner_id !== 16'd7) begin errors++; $display("FAIL single_hold got %b/%0d want 1/7", found, winner_id); end
    endtask

    task automatic test_max_q;
        int lat;
        mem[11'h010] = 16'd3;
        set_entry(0, 4, 10, 9);
        set_entry(1, 5, 50, 9);
        set_entry(2, 6, 30, 1);
        run_scan(0, lat);
        checks++; if (lat !== 26) begin errors++; $display("FAIL maxq_latency got %0d want 26", lat); end
        checks++; if (winner_id !== 16'd5 || winner_hops !== 16'd9) begin errors++; $display("FAIL maxq_winner got %0d/%0d want 5/9", winner_id, winner_hops); end
    endtask

    task automatic test_tie;
        int lat;
        logic [15:0] exp_id;
        mem[11'h010] = 16'd3;
        set_entry(0, 1, 20, 4);
        set_entry(1, 2, 20, 2);
        set_entry(2, 3, 20, 2);
        run_scan(0, lat);
`ifdef WINNER_RNG_TIEBREAK_EN
        exp_id = tie_bit ? 16'd3 : 16'd2;
`else
        exp_id = 16'd2;
`endif
        checks++; if (winner_id !== exp_id || winner_hops !== 16'd2) begin errors++; $display("FAIL tie_winner got %0d/%0d want %0d/2", winner_id, winner_hops, exp_id); end
        checks++; if (mem[11'h008] !== exp_id) begin errors++; $display("FAIL tie_mem got %0d want %0d", mem[11'h008], exp_id); end
    endtask

    task automatic test_clamp(input int pause_at, input int exp_lat);
        int lat;
        mem[11'h010] = 16'd40;
        for (int i = 0; i < 40; i++) set_entry(i, 100 + i, (i < 16) ? i : 500, i);
        run_scan(pause_at, lat);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL clamp_latency pause=%0d got %0d want %0d", pause_at, lat, exp_lat); end
        checks++; if (winner_id !== 16'd115 || winner_hops !== 16'd15) begin errors++; $display("FAIL clamp_winner pause=%0d got %0d/%0d want 115/15", pause_at, winner_id, winner_hops); end
        checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL clamp_writes pause=%0d got %0d want 2", pause_at, wr_cnt); end
    endtask

    task automatic test_reset_midscan;
        int lat;
        mem[11'h010] = 16'd3;
        set_entry(0, 4, 10, 9);
        set_entry(1, 5, 50, 9);
        set_entry(2, 6, 30, 1);
        mem[11'h008] = 16'hDEAD;
        mem[11'h009] = 16'hDEAD;
        @(negedge clock);
        wr_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (lat < 23) begin
            @(negedge clock);
            lat++;
        end
        nrst = 1'b0;
        @(negedge clock);
        checks++; if (done !== 1'b0 || found !== 1'b0 || winner_id !== 16'h0 || winner_hops !== 16'h0) begin errors++; $display("FAIL abort_outputs got %b/%b/%0d/%0d want 0/0/0/0", done, found, winner_id, winner_hops); end
        @(negedge clock);
        nrst = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (wr_cnt !== 0 || done_cnt !== 0 || mem[11'h008] !== 16'hDEAD) begin errors++; $display("FAIL abort_nowrite got wr=%0d done=%0d mem=%h want 0/0/dead", wr_cnt, done_cnt, mem[11'h008]); end
        run_scan(0, lat);
        checks++; if (lat !== 26 || winner_id !== 16'd5 || mem[11'h008] !== 16'd5) begin errors++; $display("FAIL abort_restart got lat=%0d id=%0d mem=%0d want 26/5/5", lat, winner_id, mem[11'h008]); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int first;
        mem[11'h010] = 16'd1;
        set_entry(0, 9, 3, 1);
        @(negedge clock);
        done_cnt = 0;
        start = 1'b1;
        @(negedge clock);
        lat = 1;
        first = -1;
        while (lat < 60 && !(done === 1'b1 && first >= 0)) begin
            if (done === 1'b1) first = lat;
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        checks++; if (first !== 12) begin errors++; $display("FAIL b2b_first got %0d want 12", first); end
        checks++; if (lat !== 25 || done !== 1'b1) begin errors++; $display("FAIL b2b_second got %0d want 25", lat); end
        @(negedge clock);
        checks++; if (done_cnt !== 2 || winner_id !== 16'd9) begin errors++; $display("FAIL b2b_count got %0d/%0d want 2/9", done_cnt, winner_id); end
        repeat (15) @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        test_reset();
        test_count_zero();
        test_single();
        test_max_q();
        test_tie();
        test_clamp(0, 117);
        test_clamp(30, 122);
        test_reset_midscan();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
